// File: rtl/priority_scan_pkg.sv
// Shared definitions for the priority scan encoder.
//   state_t           : two-state controller encoding (IDLE, SCAN)
//   NONE_CODE_DEFAULT : index reported for an all-zero request vector
//   MAX_WIDTH         : widest request vector the helper function handles
//   pop_is_one()      : true when exactly one bit of the argument is set
package priority_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [7:0] NONE_CODE_DEFAULT = 8'hF0;
    localparam int         MAX_WIDTH         = 256;

    // Narrower vectors are zero-extended by the caller; x & (x-1) clears the
    // lowest set bit, so a non-zero x with nothing left over has one bit set.
    function automatic logic pop_is_one(input logic [MAX_WIDTH-1:0] v);
        return (v != '0) && ((v & (v - MAX_WIDTH'(1))) == '0);
    endfunction

endpackage

// File: rtl/pse_find_first.sv
// Combinational first-set-bit finder.
// Ports:
//   vec       in  [WIDTH]  vector to search
//   msb_first in  1        1 = report highest set bit, 0 = lowest
//   idx       out [IDX_W]  position of the reported bit (0 when vec is zero)
//   onehot    out [WIDTH]  one-hot mask of the reported bit (0 when vec is zero)
//   any       out 1        vec has at least one bit set
module pse_find_first #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic             msb_first,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] onehot,
    output logic             any
);

    // The last match in scan order wins, so scanning upward finds the
    // highest set bit and scanning downward finds the lowest.
    always_comb begin
        idx = '0;
        any = |vec;
        if (msb_first) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

    // Built by comparison rather than by indexing so a non-power-of-2 WIDTH
    // never addresses a bit beyond WIDTH-1.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            onehot[i] = any && (IDX_W'(i) == idx);
        end
    end

endmodule

// File: rtl/priority_scan_encoder.sv
// Sequential priority scan encoder: accepts a request vector and streams the
// index of every set bit, one per output beat, MSB-first or LSB-first as
// chosen with each vector. An all-zero vector yields one NONE_CODE beat.
//
// Optional feature macro: PRIORITY_SCAN_ONEHOT_EN adds port out_onehot.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   in_vec / in_msb_first valid
//   in_ready     out  block can accept a vector (state IDLE)
//   in_vec       in   [WIDTH] request vector
//   in_msb_first in   1 = highest index first, 0 = lowest first
//   out_valid    out  out_idx / out_last / out_none valid (state SCAN)
//   out_ready    in   consumer accepts the current beat
//   out_idx      out  [OUT_W] index of current bit, or NONE_CODE
//   out_last     out  final beat for this vector
//   out_none     out  vector was all-zero
//   out_onehot   out  [WIDTH] mask of reported bit (macro builds only)
//   busy         out  a vector is held (state SCAN)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends combinationally on ready, and while valid is
// high without ready the payload holds stable.
module priority_scan_encoder
    import priority_scan_pkg::*;
#(
    parameter int         WIDTH     = 16,
    parameter int         OUT_W     = 8,
    parameter logic [7:0] NONE_CODE = NONE_CODE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
`ifdef PRIORITY_SCAN_ONEHOT_EN
    output logic [WIDTH-1:0] out_onehot,
`endif
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             dir_q, dir_d;

    logic [IDX_W-1:0] ff_idx;
    logic [WIDTH-1:0] ff_onehot;
    logic             ff_any;
    logic             last_raw;

    pse_find_first #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_find (
        .vec       (res_q),
        .msb_first (dir_q),
        .idx       (ff_idx),
        .onehot    (ff_onehot),
        .any       (ff_any)
    );

    // A zero residual only occurs for a vector that was zero when loaded,
    // and that vector is a single beat.
    assign last_raw = !ff_any || pop_is_one(MAX_WIDTH'(res_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    res_d   = in_vec;
                    dir_d   = in_msb_first;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (last_raw) begin
                        res_d   = '0;
                        state_d = IDLE;
                    end else begin
                        res_d = res_q & ~ff_onehot;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                res_d   = '0;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SCAN);
    assign busy      = (state_q == SCAN);

    // Payload is forced to zero outside SCAN so the idle residual (zero)
    // does not masquerade as a NONE beat.
    always_comb begin
        out_idx  = '0;
        out_last = 1'b0;
        out_none = 1'b0;
        if (state_q == SCAN) begin
            out_none = !ff_any;
            out_last = last_raw;
            out_idx  = ff_any ? OUT_W'(ff_idx) : OUT_W'(NONE_CODE);
        end
    end

`ifdef PRIORITY_SCAN_ONEHOT_EN
    assign out_onehot = (state_q == SCAN) ? ff_onehot : '0;
`endif

endmodule

// File: tb/tb_priority_scan_encoder.sv
module tb_priority_scan_encoder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // main instance, WIDTH = 16
    logic        in_valid, in_ready, in_msb_first;
    logic [15:0] in_vec;
    logic        out_valid, out_ready, out_last, out_none, busy;
    logic [7:0]  out_idx;
    logic [15:0] out_onehot;

    // small instance, WIDTH = 5
    logic        s_in_valid, s_in_ready, s_in_msb_first;
    logic [4:0]  s_in_vec;
    logic        s_out_valid, s_out_ready, s_out_last, s_out_none, s_busy;
    logic [7:0]  s_out_idx;
    logic [4:0]  s_out_onehot;

    priority_scan_encoder #(.WIDTH(16), .OUT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_msb_first(in_msb_first),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .out_none(out_none),
`ifdef PRIORITY_SCAN_ONEHOT_EN
        .out_onehot(out_onehot),
`endif
        .busy(busy)
    );

    priority_scan_encoder #(.WIDTH(5), .OUT_W(8)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_vec(s_in_vec), .in_msb_first(s_in_msb_first),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_idx(s_out_idx),
        .out_last(s_out_last), .out_none(s_out_none),
`ifdef PRIORITY_SCAN_ONEHOT_EN
        .out_onehot(s_out_onehot),
`endif
        .busy(s_busy)
    );

`ifndef PRIORITY_SCAN_ONEHOT_EN
    assign out_onehot   = '0;
    assign s_out_onehot = '0;
`endif

    // ---------------- scoreboard ----------------
    // item = {onehot[15:0], idx[7:0], last, none}
    logic [25:0] exp_q[$];
    logic [25:0] s_exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    task automatic exp_beat(input logic [7:0] idx, input logic last, input logic none, input logic [15:0] oh);
        exp_q.push_back({oh, idx, last, none});
    endtask

    task automatic s_exp_beat(input logic [7:0] idx, input logic last, input logic none, input logic [4:0] oh);
        s_exp_q.push_back({11'd0, oh, idx, last, none});
    endtask

    // ---------------- monitors ----------------
    logic       stall_prev = 1'b0;
    logic       last_prev  = 1'b0;
    logic       rst_prev   = 1'b1;
    logic [7:0] idx_prev   = '0;

    always @(negedge clk) begin
        logic [25:0] item;
        if (last_prev && !rst_prev) begin
            check("bubble_in_ready", 32'(in_ready), 32'd1);
            check("bubble_out_valid", 32'(out_valid), 32'd0);
        end
        if (stall_prev && !rst_prev) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_idx", 32'(out_idx), 32'(idx_prev));
        end
        if (out_valid === 1'b1 && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got idx %0h expected no beat", out_idx);
            end else begin
                item = exp_q.pop_front();
                check("beat_idx", 32'(out_idx), 32'(item[9:2]));
                check("beat_last", 32'(out_last), 32'(item[1]));
                check("beat_none", 32'(out_none), 32'(item[0]));
`ifdef PRIORITY_SCAN_ONEHOT_EN
                check("beat_onehot", 32'(out_onehot), 32'(item[25:10]));
`endif
            end
        end
        stall_prev = (out_valid === 1'b1) && !out_ready && !rst;
        last_prev  = (out_valid === 1'b1) && out_ready && out_last && !rst;
        idx_prev   = out_idx;
        rst_prev   = rst;
    end

    always @(negedge clk) begin
        logic [25:0] item;
        if (s_out_valid === 1'b1 && s_out_ready && !rst) begin
            if (s_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_unexpected_beat: got idx %0h expected no beat", s_out_idx);
            end else begin
                item = s_exp_q.pop_front();
                check("s_beat_idx", 32'(s_out_idx), 32'(item[9:2]));
                check("s_beat_last", 32'(s_out_last), 32'(item[1]));
                check("s_beat_none", 32'(s_out_none), 32'(item[0]));
`ifdef PRIORITY_SCAN_ONEHOT_EN
                check("s_beat_onehot", 32'(s_out_onehot), 32'(item[14:10]));
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] v, input logic msb);
        int n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_in_ready_timeout", 32'(in_ready), 32'd1);
        in_vec       = v;
        in_msb_first = msb;
        in_valid     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec   = ~v;
        check("first_beat_valid", 32'(out_valid), 32'd1);
        check("accept_in_ready_low", 32'(in_ready), 32'd0);
    endtask

    task automatic s_send(input logic [4:0] v, input logic msb);
        int n = 0;
        @(posedge clk); #1;
        while (!s_in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("s_send_in_ready_timeout", 32'(s_in_ready), 32'd1);
        s_in_vec       = v;
        s_in_msb_first = msb;
        s_in_valid     = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        s_in_vec   = ~v;
        check("s_first_beat_valid", 32'(s_out_valid), 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || s_exp_q.size() != 0 || !in_ready || !s_in_ready) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_main_queue", 32'(exp_q.size()), 32'd0);
        check("drain_small_queue", 32'(s_exp_q.size()), 32'd0);
        exp_q.delete();
        s_exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_vec = '0; in_msb_first = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_vec = '0; s_in_msb_first = 1'b0; s_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_none", 32'(out_none), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_onehot", 32'(out_onehot), 32'd0);
        check("rst_s_in_ready", 32'(s_in_ready), 32'd1);
        rst = 1'b0;

        // 8421 MSB-first: 15, 10, 5, 0
        exp_beat(8'd15, 1'b0, 1'b0, 16'h8000);
        exp_beat(8'd10, 1'b0, 1'b0, 16'h0400);
        exp_beat(8'd5,  1'b0, 1'b0, 16'h0020);
        exp_beat(8'd0,  1'b1, 1'b0, 16'h0001);
        send(16'h8421, 1'b1);
        wait_drain();

        // 8421 LSB-first: 0, 5, 10, 15
        exp_beat(8'd0,  1'b0, 1'b0, 16'h0001);
        exp_beat(8'd5,  1'b0, 1'b0, 16'h0020);
        exp_beat(8'd10, 1'b0, 1'b0, 16'h0400);
        exp_beat(8'd15, 1'b1, 1'b0, 16'h8000);
        send(16'h8421, 1'b0);
        wait_drain();

        // all-zero vector: single sentinel beat
        exp_beat(8'hF0, 1'b1, 1'b1, 16'h0000);
        send(16'h0000, 1'b1);
        wait_drain();

        // only bit 0, MSB-first
        exp_beat(8'd0, 1'b1, 1'b0, 16'h0001);
        send(16'h0001, 1'b1);
        wait_drain();

        // all ones with random back-pressure and ignored input pulses
        for (int i = 15; i >= 0; i--) exp_beat(8'(i), (i == 0), 1'b0, 16'(1) << i);
        send(16'hFFFF, 1'b1);
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            if (exp_q.size() > 2 && (n % 3) == 0) begin
                in_valid = 1'b1; in_vec = 16'h1234; in_msb_first = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // reset in SCAN after first beat: bit 6 must never appear
        exp_beat(8'd7, 1'b0, 1'b0, 16'h0080);
        send(16'h00C0, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // WIDTH = 5 instance
        s_exp_beat(8'd4, 1'b0, 1'b0, 5'b10000);
        s_exp_beat(8'd0, 1'b1, 1'b0, 5'b00001);
        s_send(5'b10001, 1'b1);
        wait_drain();
        s_exp_beat(8'd0, 1'b0, 1'b0, 5'b00001);
        s_exp_beat(8'd4, 1'b1, 1'b0, 5'b10000);
        s_send(5'b10001, 1'b0);
        wait_drain();
        for (int i = 4; i >= 0; i--) s_exp_beat(8'(i), (i == 0), 1'b0, 5'(1) << i);
        s_send(5'b11111, 1'b1);
        wait_drain();
        s_exp_beat(8'hF0, 1'b1, 1'b1, 5'b00000);
        s_send(5'b00000, 1'b0);
        wait_drain();

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
